// File: rtl/seg_scan_capture.sv
// Captures a multiplexed 7-segment display scan into per-digit hex nibbles.
// Inputs are synchronized and debounced, then each capture is decoded and checked for a complete 0..7 frame.
module seg_scan_capture #(
   parameter int STABLE_CYC  = 4,
   parameter bit SEG_ACT_LOW = 1
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [7:0]  led_sel,
   input  logic [7:0]  seg_in,
   input  logic        clr,
   output logic [31:0] digits,
   output logic [7:0]  dp_flags,
   output logic [7:0]  digit_valid,
   output logic        frame_done,
   output logic        sel_err,
   output logic        seg_err
);

   localparam int CW = $clog2(STABLE_CYC + 1);

   typedef enum logic {
      S_IDLE,
      S_TRACK
   } state_t;

   logic [7:0]    r_selMeta, r_selSync, r_segMeta, r_segSync;
   logic [7:0]    r_prevSel, r_prevSeg;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_digits;
   logic [7:0]    r_dpFlags, r_digitValid;
   logic          r_frameDone, r_selErr, r_segErr;
   state_t        r_state;
   logic [2:0]    r_expect;

   logic          w_same, w_capture;
   logic          w_blank, w_oneHot, w_selValid, w_write, w_selBad, w_segBad;
   logic [2:0]    w_idx;
   logic [7:0]    w_segAh;
   logic [3:0]    w_nib;
   logic          w_segOk;
   state_t        w_stateNext;
   logic [2:0]    w_expectNext;
   logic          w_frameHit;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_selMeta <= 8'hFF;
         r_selSync <= 8'hFF;
         r_segMeta <= 8'hFF;
         r_segSync <= 8'hFF;
      end else begin
         r_selMeta <= led_sel;
         r_selSync <= r_selMeta;
         r_segMeta <= seg_in;
         r_segSync <= r_segMeta;
      end
   end

   // The counter saturates, so a pair held indefinitely yields a single capture.
   assign w_same    = ({r_selSync, r_segSync} == {r_prevSel, r_prevSeg});
   assign w_capture = w_same && (r_cnt == CW'(STABLE_CYC - 1));

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_prevSel <= 8'hFF;
         r_prevSeg <= 8'hFF;
         r_cnt     <= '0;
      end else begin
         r_prevSel <= r_selSync;
         r_prevSeg <= r_segSync;
         if (!w_same)
            r_cnt <= '0;
         else if (r_cnt != CW'(STABLE_CYC))
            r_cnt <= r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_idx = 3'd0;
      for (int i = 0; i < 8; i++)
         if (!r_selSync[i])
            w_idx = 3'(i);
   end

   assign w_blank  = (r_selSync == 8'hFF);
   assign w_oneHot = ($countones(~r_selSync) == 1);
   assign w_segAh  = SEG_ACT_LOW ? ~r_segSync : r_segSync;

   always_comb begin
      w_nib   = 4'h0;
      w_segOk = 1'b1;
      case (w_segAh[6:0])
         7'h3F: w_nib = 4'h0;
         7'h06: w_nib = 4'h1;
         7'h5B: w_nib = 4'h2;
         7'h4F: w_nib = 4'h3;
         7'h66: w_nib = 4'h4;
         7'h6D: w_nib = 4'h5;
         7'h7D: w_nib = 4'h6;
         7'h07: w_nib = 4'h7;
         7'h7F: w_nib = 4'h8;
         7'h6F: w_nib = 4'h9;
         7'h77: w_nib = 4'hA;
         7'h7C: w_nib = 4'hB;
         7'h39: w_nib = 4'hC;
         7'h5E: w_nib = 4'hD;
         7'h79: w_nib = 4'hE;
         7'h71: w_nib = 4'hF;
         default: w_segOk = 1'b0;
      endcase
   end

   assign w_selValid = w_capture && w_oneHot;
   assign w_write    = w_selValid && w_segOk;
   assign w_selBad   = w_capture && !w_blank && !w_oneHot;
   assign w_segBad   = w_selValid && !w_segOk;

   // clr wins over a same-cycle capture and also suppresses its error pulse.
   always_ff @(posedge sys_clk) begin
      if (sys_rst || clr) begin
         r_digits     <= '0;
         r_dpFlags    <= '0;
         r_digitValid <= '0;
         r_selErr     <= 1'b0;
         r_segErr     <= 1'b0;
      end else begin
         r_selErr <= w_selBad;
         r_segErr <= w_segBad;
         if (w_write) begin
            r_digits[4*w_idx +: 4] <= w_nib;
            r_dpFlags[w_idx]       <= w_segAh[7];
            r_digitValid[w_idx]    <= 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst || clr) begin
         r_state     <= S_IDLE;
         r_expect    <= 3'd0;
         r_frameDone <= 1'b0;
      end else begin
         r_state     <= w_stateNext;
         r_expect    <= w_expectNext;
         r_frameDone <= w_frameHit;
      end
   end

   // Only successful writes move the tracker; blanks and errors leave it alone.
   always_comb begin
      w_stateNext  = r_state;
      w_expectNext = r_expect;
      w_frameHit   = 1'b0;
      if (w_write) begin
         case (r_state)
            S_IDLE: begin
               if (w_idx == 3'd0) begin
                  w_stateNext  = S_TRACK;
                  w_expectNext = 3'd1;
               end
            end
            S_TRACK: begin
               if (w_idx == r_expect) begin
                  if (w_idx == 3'd7) begin
                     w_stateNext  = S_IDLE;
                     w_expectNext = 3'd0;
                     w_frameHit   = 1'b1;
                  end else begin
                     w_expectNext = r_expect + 3'd1;
                  end
               end else if (w_idx == 3'd0) begin
                  w_expectNext = 3'd1;
               end else begin
                  w_stateNext  = S_IDLE;
                  w_expectNext = 3'd0;
               end
            end
            default: begin
               w_stateNext  = S_IDLE;
               w_expectNext = 3'd0;
            end
         endcase
      end
   end

   assign digits      = r_digits;
   assign dp_flags    = r_dpFlags;
   assign digit_valid = r_digitValid;
   assign frame_done  = r_frameDone;
   assign sel_err     = r_selErr;
   assign seg_err     = r_segErr;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: scans, glitches, illegal selects, bad segments, clr and reset.
// Inputs change on the falling edge; outputs and pulse counters are sampled on the falling edge.
module tb_seg_scan_capture;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [7:0]  led_sel;
   logic [7:0]  seg_in;
   logic        clr;
   logic [31:0] digits;
   logic [7:0]  dp_flags;
   logic [7:0]  digit_valid;
   logic        frame_done;
   logic        sel_err;
   logic        seg_err;

   int nChecks = 0;
   int nPass = 0;
   int frameCnt = 0;
   int selErrCnt = 0;
   int segErrCnt = 0;
   int overlapCnt = 0;

   always #10 sys_clk = ~sys_clk;

   seg_scan_capture dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .led_sel     (led_sel),
      .seg_in      (seg_in),
      .clr         (clr),
      .digits      (digits),
      .dp_flags    (dp_flags),
      .digit_valid (digit_valid),
      .frame_done  (frame_done),
      .sel_err     (sel_err),
      .seg_err     (seg_err)
   );

   // Counting cycles high (not edges) also exposes pulses that stick for more than a cycle.
   always @(negedge sys_clk) begin
      frameCnt  += int'(frame_done);
      selErrCnt += int'(sel_err);
      segErrCnt += int'(seg_err);
      if ((int'(frame_done) + int'(sel_err) + int'(seg_err)) > 1)
         overlapCnt++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs === exp)
         nPass++;
      else
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   task automatic applyStimulus(input logic [7:0] sel, input logic [7:0] seg, input int cycles);
      led_sel = sel;
      seg_in  = seg;
      repeat (cycles) @(negedge sys_clk);
   endtask

   function automatic logic [7:0] segCode(input int n);
      logic [6:0] ah;
      case (n)
         0: ah = 7'h3F;  1: ah = 7'h06;  2: ah = 7'h5B;  3: ah = 7'h4F;
         4: ah = 7'h66;  5: ah = 7'h6D;  6: ah = 7'h7D;  7: ah = 7'h07;
         8: ah = 7'h7F;  9: ah = 7'h6F; 10: ah = 7'h77; 11: ah = 7'h7C;
        12: ah = 7'h39; 13: ah = 7'h5E; 14: ah = 7'h79; default: ah = 7'h71;
      endcase
      return {1'b1, ~ah};
   endfunction

   task automatic scanIdx(input int idx, input int nib);
      logic [7:0] sel;
      sel = ~(8'h01 << idx);
      applyStimulus(sel, segCode(nib), 10);
   endtask

   initial begin
      sys_rst = 1'b1;
      clr     = 1'b0;
      led_sel = 8'hFF;
      seg_in  = 8'hFF;
      repeat (3) @(negedge sys_clk);
      checkOutput("rst_digits", digits, 32'h0);
      checkOutput("rst_dp", {24'h0, dp_flags}, 32'h0);
      checkOutput("rst_valid", {24'h0, digit_valid}, 32'h0);
      checkOutput("rst_pulses", {29'h0, frame_done, sel_err, seg_err}, 32'h0);
      sys_rst = 1'b0;
      applyStimulus(8'hFF, 8'hFF, 10);

      // Full in-order scan with the reference segment codes.
      for (int i = 0; i < 8; i++) scanIdx(i, i);
      applyStimulus(8'hFF, 8'hFF, 10);
      checkOutput("scan_digits", digits, 32'h7654_3210);
      checkOutput("scan_valid", {24'h0, digit_valid}, 32'hFF);
      checkOutput("scan_dp", {24'h0, dp_flags}, 32'h0);
      checkOutput("scan_frame", frameCnt, 1);
      checkOutput("scan_selerr", selErrCnt, 0);
      checkOutput("scan_segerr", segErrCnt, 0);

      // Short glitch that would decode to 8 with dp off on digit 2.
      applyStimulus(8'hFB, 8'h80, 3);
      applyStimulus(8'hFF, 8'hFF, 10);
      checkOutput("glitch_digits", digits, 32'h7654_3210);
      checkOutput("glitch_dp", {24'h0, dp_flags}, 32'h0);
      checkOutput("glitch_valid", {24'h0, digit_valid}, 32'hFF);

      applyStimulus(8'hFC, 8'hC0, 10);
      checkOutput("illsel_err", selErrCnt, 1);
      checkOutput("illsel_digits", digits, 32'h7654_3210);
      applyStimulus(8'hFF, 8'hFF, 10);
      checkOutput("blank_noerr", selErrCnt, 1);

      // Digit 0 gets 5 with dp lit, then an undecodable all-off pattern.
      applyStimulus(8'hFE, 8'h12, 10);
      checkOutput("dp_digits", digits, 32'h7654_3215);
      checkOutput("dp_flags", {24'h0, dp_flags}, 32'h01);
      applyStimulus(8'hFE, 8'hFF, 10);
      checkOutput("badseg_err", segErrCnt, 1);
      checkOutput("badseg_digits", digits, 32'h7654_3215);
      applyStimulus(8'hFF, 8'hFF, 10);

      // Order break 0,1,3,4..7 then a clean 0..7 scan.
      scanIdx(0, 8); scanIdx(1, 9); scanIdx(3, 11);
      for (int i = 4; i < 8; i++) scanIdx(i, i + 8);
      applyStimulus(8'hFF, 8'hFF, 10);
      checkOutput("break_noframe", frameCnt, 1);
      for (int i = 0; i < 8; i++) scanIdx(i, 7 - i);
      applyStimulus(8'hFF, 8'hFF, 10);
      checkOutput("clean_frame", frameCnt, 2);
      checkOutput("clean_digits", digits, 32'h0123_4567);

      // clr lands exactly on the capture edge (7th rising edge after the change).
      led_sel = 8'hFE;
      seg_in  = segCode(1);
      repeat (6) @(negedge sys_clk);
      clr = 1'b1;
      @(negedge sys_clk);
      clr = 1'b0;
      repeat (5) @(negedge sys_clk);
      checkOutput("clr_digits", digits, 32'h0);
      checkOutput("clr_dp", {24'h0, dp_flags}, 32'h0);
      checkOutput("clr_valid", {24'h0, digit_valid}, 32'h0);
      checkOutput("clr_frame", frameCnt, 2);

      // Latency: outputs must appear on the 7th rising edge, not earlier.
      led_sel = 8'hFD;
      seg_in  = segCode(2);
      repeat (6) @(negedge sys_clk);
      checkOutput("lat_early", {24'h0, digit_valid}, 32'h0);
      @(negedge sys_clk);
      checkOutput("lat_valid", {24'h0, digit_valid}, 32'h02);
      checkOutput("lat_digits", digits, 32'h0000_0020);
      applyStimulus(8'hFF, 8'hFF, 10);

      // Reset after index 4 abandons the frame.
      for (int i = 0; i < 5; i++) scanIdx(i, i);
      led_sel = 8'hFF;
      seg_in  = 8'hFF;
      sys_rst = 1'b1;
      repeat (3) @(negedge sys_clk);
      checkOutput("midrst_digits", digits, 32'h0);
      checkOutput("midrst_valid", {24'h0, digit_valid}, 32'h0);
      sys_rst = 1'b0;
      for (int i = 5; i < 8; i++) scanIdx(i, i);
      applyStimulus(8'hFF, 8'hFF, 10);
      checkOutput("midrst_noframe", frameCnt, 2);
      checkOutput("midrst_valid2", {24'h0, digit_valid}, 32'hE0);
      checkOutput("midrst_digits2", digits, 32'h7650_0000);

      checkOutput("pulse_exclusive", overlapCnt, 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/seg_scan_capture.md
SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Interface
REQ-001 The block SHALL have parameter STABLE_CYC, default 4: the number of consecutive identical samples required before a capture.
REQ-002 The block SHALL have parameter SEG_ACT_LOW, default 1: 1 = segment lines active-low, 0 = segment lines active-high.
REQ-003 sys_clk  input  1  the single clock, 50 MHz.
REQ-004 sys_rst  input  1  reset, synchronous, active-high.
REQ-005 led_sel  input  8  scanned digit select: one-hot active-low, bit i low selects digit i.
REQ-006 seg_in  input  8  segment bus {dp,g,f,e,d,c,b,a}.
REQ-007 clr  input  1  synchronous clear of the captured contents.
REQ-008 digits  output  32  decoded nibbles; digit i is at bits [4i+3:4i].
REQ-009 dp_flags  output  8  decimal-point state per digit, 1 = lit.
REQ-010 digit_valid  output  8  bit i = digit i captured since the last reset or clr.
REQ-011 frame_done  output  1  one-cycle pulse when digits 0..7 are captured in rotation order.
REQ-012 sel_err  output  1  one-cycle pulse for an illegal select pattern.
REQ-013 seg_err  output  1  one-cycle pulse for an undecodable segment pattern.

Function
REQ-014 led_sel and seg_in SHALL each pass through a 2-flop synchronizer before any use.
REQ-015 Stability counter:
- cleared to 0 when the synchronized {sel,seg} pair differs from the previous cycle's pair;
- otherwise increments, saturating at STABLE_CYC.
REQ-016 A capture event SHALL occur on exactly the cycle the counter goes from STABLE_CYC-1 to STABLE_CYC: one event per stable pair, however long it is held.
REQ-017 Capture classification:
- sel == 8'hFF: blank; no write, no error;
- exactly one zero bit: valid, index = position of that bit;
- any other pattern: sel_err pulse, no write.
REQ-018 Segment decode uses seg[6:0], inverted first when SEG_ACT_LOW=1. Active-high map, 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
REQ-019 An unmatched segment pattern on a valid select SHALL pulse seg_err and leave that digit unchanged.
REQ-020 Valid select with a decodable pattern: update digits[index], dp_flags[index] = decoded dp, and set digit_valid[index], all registered on the capture edge.
REQ-021 Frame tracker FSM:
- IDLE: capture of index 0 -> TRACK with expect = 1;
- TRACK: capture of index == expect -> expect+1;
- TRACK: capture of index 7 == expect -> frame_done pulse, return to IDLE;
- TRACK: out-of-order index 0 -> TRACK with expect = 1;
- TRACK: any other out-of-order index -> IDLE;
- blank captures and error captures do not change the FSM.
REQ-022 Total latency: a pair held constant from input edge k SHALL produce its capture-driven outputs at edge k+STABLE_CYC+2; a pair held fewer cycles SHALL be ignored.
REQ-023 clr SHALL zero digits, dp_flags and digit_valid, and force IDLE. clr has priority over a simultaneous capture, whose data is discarded.
REQ-024 frame_done, sel_err and seg_err SHALL be mutually exclusive in any cycle and SHALL never be asserted for more than one cycle per event.

Reset
REQ-025 With sys_rst high at a clock edge: digits = 0, dp_flags = 0, digit_valid = 0, all pulses = 0, FSM = IDLE, stability counter = 0, synchronizers = {8'hFF,8'hFF}.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; no frame_done is issued for data captured before reset.

Verification
REQ-027 Full scan: sel FE,FD,...,7F with seg C0,F9,A4,B0,99,92,82,F8, each held 10 cycles -> digits = 32'h7654_3210, digit_valid = FF, exactly one frame_done after index 7.
REQ-028 Glitch: sel=FB, seg=80, held 3 cycles (STABLE_CYC=4) -> no capture, digit_valid unchanged.
REQ-029 Illegal select: sel=FC held 10 cycles -> one sel_err pulse, no write; then sel=FF -> no error.
REQ-030 Bad segment: sel=FE, seg=FF (blank digit pattern) -> one seg_err pulse, digits[3:0] unchanged.
REQ-031 Order break: indices 0,1,3 then 4..7 -> no frame_done; a following clean 0..7 scan -> one frame_done.
REQ-032 clr and capture in the same cycle -> all outputs zero afterwards; sys_rst mid-scan at index 4, then indices 5..7 -> no frame_done.
